// File: rtl/logic_pkg.sv
// Shared opcode and state definitions for the bitwise logic unit and its command issuer.
package logic_pkg;

  localparam logic [2:0] LOP_AND  = 3'd0;
  localparam logic [2:0] LOP_OR   = 3'd1;
  localparam logic [2:0] LOP_XOR  = 3'd2;
  localparam logic [2:0] LOP_NOT  = 3'd3;
  localparam logic [2:0] LOP_NAND = 3'd4;
  localparam logic [2:0] LOP_NOR  = 3'd5;
  localparam logic [2:0] LOP_XNOR = 3'd6;
  localparam logic [2:0] LOP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_reserved(input logic [2:0] op);
    return op == LOP_RSVD;
  endfunction

endpackage

// File: rtl/logic_op_issuer.sv
// Command-side front end for the combinational logic unit: one op per handshake,
// registered operands to the unit, captured result on a response channel, chaining accumulator.
module logic_op_issuer
  import logic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic                  cmd_acc,
  output logic [DATA_WIDTH-1:0] lu_a,
  output logic [DATA_WIDTH-1:0] lu_b,
  output logic [2:0]            lu_op,
  input  logic [DATA_WIDTH-1:0] lu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [CNT_WIDTH-1:0]  op_count
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          b_d     = cmd_b;
          a_d     = cmd_acc ? acc_q : cmd_a;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Operands have been stable on lu_* for the whole cycle; sample the unit's result.
        rsp_data_d = lu_result;
        acc_d      = lu_result;
        rsp_err_d  = is_reserved(op_q);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_WIDTH'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      op_count_q <= op_count_d;
    end
  end

  // Handshake flags decode straight from the state flops, so they are glitch-free.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign lu_a      = a_q;
  assign lu_b      = b_q;
  assign lu_op     = op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_op_issuer.sv
// Self-checking bench for logic_op_issuer paired with a behavioural logic unit;
// table-driven vectors plus hand sequences for backpressure and mid-operation reset.
module tb_logic_op_issuer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_acc = 1'b0;
  logic [7:0] lu_a, lu_b, lu_result;
  logic [2:0] lu_op;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [15:0] op_count;

  logic_op_issuer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_result(lu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External combinational logic unit; reserved opcode returns 0.
  always_comb begin
    lu_result = 8'h00;
    case (lu_op)
      3'd0: lu_result = lu_a & lu_b;
      3'd1: lu_result = lu_a | lu_b;
      3'd2: lu_result = lu_a ^ lu_b;
      3'd3: lu_result = ~lu_a;
      3'd4: lu_result = ~(lu_a & lu_b);
      3'd5: lu_result = ~(lu_a | lu_b);
      3'd6: lu_result = ~(lu_a ^ lu_b);
      default: lu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t sb_q[$];
  int total = 0;
  int bad = 0;
  logic [7:0]  model_acc = 8'h00;
  logic [15:0] model_cnt = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives a command until accepted; called #1 after a clock edge.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic acc, input logic [7:0] ed, input logic ee);
    int wait_cyc = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_valid = 1'b1;
    while (!cmd_ready && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sb_q.push_back('{data: ed, err: ee});
    check("issue_lu_a", lu_a, acc ? model_acc : a);
    check("issue_lu_b", lu_b, b);
    check("issue_lu_op", lu_op, op);
    check("issue_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("issue_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  // Called one cycle after accept; expects rsp_valid on the next edge, holds rsp_ready low for 'hold' cycles.
  task automatic recv_rsp(input int hold);
    int wait_cyc = 0;
    rsp_t exp;
    logic [7:0] lu_a_held;
    @(posedge clk); #1;
    check("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    while (!rsp_valid && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!rsp_valid) return;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    exp = sb_q.pop_front();
    check("rsp_data", rsp_data, exp.data);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp.err});
    lu_a_held = lu_a;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, exp.data);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_lu_a_held", lu_a, lu_a_held);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_cnt = model_cnt + 16'd1;
    model_acc = exp.data;
    check("op_count", op_count, model_cnt);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{op: 3'd0, a: 8'hF0, b: 8'h3C, acc: 1'b0, exp_data: 8'h30, exp_err: 1'b0};
    vecs[1] = '{op: 3'd2, a: 8'hAA, b: 8'hFF, acc: 1'b0, exp_data: 8'h55, exp_err: 1'b0};
    vecs[2] = '{op: 3'd1, a: 8'h77, b: 8'h0F, acc: 1'b1, exp_data: 8'h5F, exp_err: 1'b0};
    vecs[3] = '{op: 3'd7, a: 8'hFF, b: 8'hFF, acc: 1'b0, exp_data: 8'h00, exp_err: 1'b1};
    vecs[4] = '{op: 3'd6, a: 8'h0F, b: 8'h0F, acc: 1'b0, exp_data: 8'hFF, exp_err: 1'b0};
    vecs[5] = '{op: 3'd3, a: 8'h5A, b: 8'h00, acc: 1'b0, exp_data: 8'hA5, exp_err: 1'b0};
    vecs[6] = '{op: 3'd4, a: 8'h00, b: 8'hF0, acc: 1'b1, exp_data: 8'h5F, exp_err: 1'b0};
    vecs[7] = '{op: 3'd5, a: 8'h0F, b: 8'h30, acc: 1'b0, exp_data: 8'hC0, exp_err: 1'b0};
    vecs[8] = '{op: 3'd0, a: 8'h11, b: 8'hFF, acc: 1'b1, exp_data: 8'hC0, exp_err: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_op_count", op_count, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_lu_a", lu_a, 32'd0);
    check("rst_lu_b", lu_b, 32'd0);
    check("rst_lu_op", lu_op, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

    // rsp_ready outside RESP must have no effect
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("idle_rsp_ready_count", op_count, 32'd0);
    check("idle_rsp_ready_valid", {31'd0, rsp_valid}, 32'd0);

    // Table vectors, including chaining and the reserved opcode
    for (int i = 0; i < 9; i++) begin
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].exp_data, vecs[i].exp_err);
      recv_rsp(0);
    end

    // Backpressure with a second command waiting
    send_cmd(3'd0, 8'hFF, 8'h0F, 1'b0, 8'h0F, 1'b0);
    cmd_op = 3'd2; cmd_a = 8'h33; cmd_b = 8'h0F; cmd_acc = 1'b0; cmd_valid = 1'b1;
    recv_rsp(5);
    send_cmd(3'd2, 8'h33, 8'h0F, 1'b0, 8'h3C, 1'b0);
    recv_rsp(1);

    // Reset while in ISSUE discards the operation
    send_cmd(3'd1, 8'hC3, 8'h00, 1'b0, 8'hC3, 1'b0);
    rst = 1'b1;
    #2;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_op_count", op_count, 32'd0);
    check("midrst_lu_a", lu_a, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    sb_q.delete();
    model_acc = 8'h00;
    model_cnt = 16'h0000;
    @(posedge clk); #1;
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send_cmd(3'd1, 8'h99, 8'h12, 1'b1, 8'h12, 1'b0);
    recv_rsp(0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
